// File: rtl/lu_arbiter_i8_if.sv
// Bundle of the requester-side handshake and the shared logic-unit bus seen by lu_arbiter_i8.
// slave is the arbiter's view; master is the environment (requesters plus shared unit).
interface lu_arbiter_i8_if #(
    parameter int N = 4,
    parameter int W = 8
);
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [N*2-1:0] req_op;

    logic           lu_valid;
    logic [W-1:0]   lu_a;
    logic [W-1:0]   lu_b;
    logic [1:0]     lu_op;
    logic [W-1:0]   lu_y;

    logic [N-1:0]   rsp_valid;
    logic [W-1:0]   rsp_y;

    modport slave (
        input  req_valid, req_a, req_b, req_op, lu_y,
        output req_ready, lu_valid, lu_a, lu_b, lu_op, rsp_valid, rsp_y
    );

    modport master (
        output req_valid, req_a, req_b, req_op, lu_y,
        input  req_ready, lu_valid, lu_a, lu_b, lu_op, rsp_valid, rsp_y
    );
endinterface

// File: rtl/lu_arbiter_i8.sv
// Round-robin sharing of one pipelined 8-bit logic unit between N requesters.
// Issues registered operands, tracks owners in a LAT-deep tag pipe and routes results back.
module lu_arbiter_i8 #(
    parameter int N   = 4,
    parameter int W   = 8,
    parameter int LAT = 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          enable,
    lu_arbiter_i8_if.slave bus,
    output logic [15:0]   issued
);
    localparam int IW = $clog2(N);

    logic [W-1:0] a_arr  [N];
    logic [W-1:0] b_arr  [N];
    logic [1:0]   op_arr [N];

    for (genvar gi = 0; gi < N; gi++) begin : g_unpack
        assign a_arr[gi]  = bus.req_a[gi*W +: W];
        assign b_arr[gi]  = bus.req_b[gi*W +: W];
        assign op_arr[gi] = bus.req_op[gi*2 +: 2];
    end

    logic [IW-1:0]          ptr_q, ptr_d;
    logic                   lu_valid_q, lu_valid_d;
    logic [W-1:0]           lu_a_q, lu_a_d;
    logic [W-1:0]           lu_b_q, lu_b_d;
    logic [1:0]             lu_op_q, lu_op_d;
    logic [IW-1:0]          issue_id_q, issue_id_d;
    logic [LAT-1:0]         tag_v_q, tag_v_d;
    logic [LAT-1:0][IW-1:0] tag_id_q, tag_id_d;
    logic [N-1:0]           rsp_valid_q, rsp_valid_d;
    logic [W-1:0]           rsp_y_q, rsp_y_d;
    logic [15:0]            issued_q, issued_d;

    logic                   gnt_found;
    logic [IW-1:0]          gnt_id;
    logic [IW:0]            cand;
    logic                   hs;
    logic [N-1:0]           req_ready_c;

    // First valid requester searching ptr, ptr+1, ... modulo N.
    always_comb begin
        gnt_found = 1'b0;
        gnt_id    = '0;
        cand      = '0;
        for (int k = 0; k < N; k++) begin
            cand = {1'b0, ptr_q} + (IW+1)'(k);
            if (cand >= (IW+1)'(N)) begin
                cand = cand - (IW+1)'(N);
            end
            if (!gnt_found && bus.req_valid[cand[IW-1:0]]) begin
                gnt_found = 1'b1;
                gnt_id    = cand[IW-1:0];
            end
        end
    end

    assign hs          = reset && enable && gnt_found;
    assign req_ready_c = hs ? (N'(1) << gnt_id) : '0;

    always_comb begin
        ptr_d      = ptr_q;
        lu_valid_d = 1'b0;
        lu_a_d     = lu_a_q;
        lu_b_d     = lu_b_q;
        lu_op_d    = lu_op_q;
        issue_id_d = issue_id_q;
        issued_d   = issued_q;
        if (hs) begin
            ptr_d      = (gnt_id == IW'(N-1)) ? '0 : gnt_id + IW'(1);
            lu_valid_d = 1'b1;
            lu_a_d     = a_arr[gnt_id];
            lu_b_d     = b_arr[gnt_id];
            lu_op_d    = op_arr[gnt_id];
            issue_id_d = gnt_id;
            issued_d   = issued_q + 16'd1;
        end
    end

    // Tag pipe entry k is the issue made k+1 cycles ago; the last stage lines up with lu_y.
    always_comb begin
        tag_v_d     = '0;
        tag_id_d    = '0;
        tag_v_d[0]  = lu_valid_q;
        tag_id_d[0] = issue_id_q;
        for (int k = 1; k < LAT; k++) begin
            tag_v_d[k]  = tag_v_q[k-1];
            tag_id_d[k] = tag_id_q[k-1];
        end
    end

    always_comb begin
        rsp_valid_d = '0;
        rsp_y_d     = rsp_y_q;
        if (tag_v_q[LAT-1]) begin
            rsp_valid_d = N'(1) << tag_id_q[LAT-1];
            rsp_y_d     = bus.lu_y;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            ptr_q       <= '0;
            lu_valid_q  <= 1'b0;
            lu_a_q      <= '0;
            lu_b_q      <= '0;
            lu_op_q     <= '0;
            issue_id_q  <= '0;
            tag_v_q     <= '0;
            tag_id_q    <= '0;
            rsp_valid_q <= '0;
            rsp_y_q     <= '0;
            issued_q    <= '0;
        end else begin
            ptr_q       <= ptr_d;
            lu_valid_q  <= lu_valid_d;
            lu_a_q      <= lu_a_d;
            lu_b_q      <= lu_b_d;
            lu_op_q     <= lu_op_d;
            issue_id_q  <= issue_id_d;
            tag_v_q     <= tag_v_d;
            tag_id_q    <= tag_id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_y_q     <= rsp_y_d;
            issued_q    <= issued_d;
        end
    end

    assign bus.req_ready = req_ready_c;
    assign bus.lu_valid  = lu_valid_q;
    assign bus.lu_a      = lu_a_q;
    assign bus.lu_b      = lu_b_q;
    assign bus.lu_op     = lu_op_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_y     = rsp_y_q;
    assign issued        = issued_q;
endmodule

// File: tb/tb_lu_arbiter_i8.sv
// Bench for lu_arbiter_i8: LAT=1 and LAT=3 instances share identical requester stimulus
// and are compared every cycle against a transaction-level round-robin/scoreboard model.
module tb_lu_arbiter_i8;
    localparam int N = 4;
    localparam int W = 8;

    logic clock  = 1'b0;
    logic reset  = 1'b0;
    logic enable = 1'b1;
    always #5 clock = ~clock;

    lu_arbiter_i8_if #(.N(N), .W(W)) bus1 ();
    lu_arbiter_i8_if #(.N(N), .W(W)) bus3 ();
    logic [15:0] issued1, issued3;

    lu_arbiter_i8 #(.N(N), .W(W), .LAT(1)) dut1 (
        .clock(clock), .reset(reset), .enable(enable), .bus(bus1), .issued(issued1));
    lu_arbiter_i8 #(.N(N), .W(W), .LAT(3)) dut3 (
        .clock(clock), .reset(reset), .enable(enable), .bus(bus3), .issued(issued3));

    logic [N-1:0]         v_r  = '0;
    logic [N-1:0][W-1:0]  a_r  = '0;
    logic [N-1:0][W-1:0]  b_r  = '0;
    logic [N-1:0][1:0]    op_r = '0;

    assign bus1.req_valid = v_r;
    assign bus1.req_a     = a_r;
    assign bus1.req_b     = b_r;
    assign bus1.req_op    = op_r;
    assign bus3.req_valid = v_r;
    assign bus3.req_a     = a_r;
    assign bus3.req_b     = b_r;
    assign bus3.req_op    = op_r;

    function automatic logic [7:0] lu_fn(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
        case (op)
            2'd0:    return a & b;
            2'd1:    return a | b;
            2'd2:    return a ^ b;
            default: return ~(a | b);
        endcase
    endfunction

    // Shared logic units; garbage on lu_y whenever the slot was not a live issue.
    logic [7:0] p1;
    logic [7:0] p3 [3];
    always @(posedge clock) begin
        p1    <= bus1.lu_valid ? lu_fn(bus1.lu_a, bus1.lu_b, bus1.lu_op) : 8'($urandom);
        p3[0] <= bus3.lu_valid ? lu_fn(bus3.lu_a, bus3.lu_b, bus3.lu_op) : 8'($urandom);
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign bus1.lu_y = p1;
    assign bus3.lu_y = p3[2];

    typedef struct {
        int         due;
        int         id;
        logic [7:0] y;
    } rsp_t;

    rsp_t       q1[$];
    rsp_t       q3[$];
    int         ptr_m   = 0;
    logic       exp_luv = 1'b0;
    logic [7:0] exp_a   = '0;
    logic [7:0] exp_b   = '0;
    logic [1:0] exp_op  = '0;
    logic [15:0] exp_iss = '0;
    logic [7:0] last1   = '0;
    logic [7:0] last3   = '0;
    int         cyc     = 0;
    int         total   = 0;
    int         bad     = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    task automatic raise(input int i);
        v_r[i]  = 1'b1;
        a_r[i]  = 8'($urandom);
        b_r[i]  = 8'($urandom);
        op_r[i] = 2'($urandom);
    endtask

    // Called just after inputs are driven at a negedge: check, advance model, return at next negedge.
    task automatic step();
        int         g;
        logic [3:0] exp_rdy;
        rsp_t       e;
        #1;
        g = -1;
        if (reset && enable) begin
            for (int k = 0; k < N; k++) begin
                int c;
                c = (ptr_m + k) % N;
                if (g < 0 && v_r[c]) g = c;
            end
        end
        exp_rdy = (g >= 0) ? (4'b0001 << g) : 4'b0000;
        chk("ready1", 32'(bus1.req_ready), 32'(exp_rdy));
        chk("ready3", 32'(bus3.req_ready), 32'(exp_rdy));
        chk("lu_valid1", 32'(bus1.lu_valid), 32'(exp_luv));
        chk("lu_valid3", 32'(bus3.lu_valid), 32'(exp_luv));
        chk("lu_a", 32'(bus1.lu_a), 32'(exp_a));
        chk("lu_b", 32'(bus1.lu_b), 32'(exp_b));
        chk("lu_op", 32'(bus1.lu_op), 32'(exp_op));
        chk("issued1", 32'(issued1), 32'(exp_iss));
        chk("issued3", 32'(issued3), 32'(exp_iss));

        if (q1.size() > 0 && q1[0].due == cyc) begin
            e = q1.pop_front();
            chk("rsp_valid1", 32'(bus1.rsp_valid), 32'(4'b0001 << e.id));
            last1 = e.y;
        end else begin
            chk("rsp_valid1", 32'(bus1.rsp_valid), 32'd0);
        end
        chk("rsp_y1", 32'(bus1.rsp_y), 32'(last1));

        if (q3.size() > 0 && q3[0].due == cyc) begin
            e = q3.pop_front();
            chk("rsp_valid3", 32'(bus3.rsp_valid), 32'(4'b0001 << e.id));
            last3 = e.y;
        end else begin
            chk("rsp_valid3", 32'(bus3.rsp_valid), 32'd0);
        end
        chk("rsp_y3", 32'(bus3.rsp_y), 32'(last3));

        if (!reset) begin
            ptr_m   = 0;
            exp_luv = 1'b0;
            exp_a   = '0;
            exp_b   = '0;
            exp_op  = '0;
            exp_iss = '0;
            last1   = '0;
            last3   = '0;
            q1.delete();
            q3.delete();
        end else begin
            exp_luv = (g >= 0);
            if (g >= 0) begin
                exp_a   = a_r[g];
                exp_b   = b_r[g];
                exp_op  = op_r[g];
                exp_iss = exp_iss + 16'd1;
                e.id    = g;
                e.y     = lu_fn(a_r[g], b_r[g], op_r[g]);
                e.due   = cyc + 3;
                q1.push_back(e);
                e.due   = cyc + 5;
                q3.push_back(e);
                ptr_m   = (g + 1) % N;
            end
        end
        cyc++;
        @(negedge clock);
        if (g >= 0 && reset) v_r[g] = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step();
        reset = 1'b1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clock);

        // Reset held two cycles, then one nor request from requester 0.
        step();
        step();
        reset   = 1'b1;
        v_r[0]  = 1'b1;
        a_r[0]  = 8'd7;
        b_r[0]  = 8'd8;
        op_r[0] = 2'd3;
        repeat (7) step();

        // All four requesters continuously valid.
        do_reset();
        for (int c = 0; c < 8; c++) begin
            for (int i = 0; i < N; i++) if (!v_r[i]) raise(i);
            step();
        end
        v_r = '0;
        repeat (7) step();

        // Opcodes and/or/xor from requesters 1..3.
        do_reset();
        for (int i = 1; i < N; i++) begin
            v_r[i]  = 1'b1;
            a_r[i]  = 8'h0F;
            b_r[i]  = 8'h3C;
            op_r[i] = 2'(i - 1);
        end
        repeat (8) step();

        // Enable dropped with two ops in flight.
        do_reset();
        raise(0);
        raise(1);
        step();
        step();
        enable = 1'b0;
        raise(2);
        raise(3);
        repeat (6) step();
        enable = 1'b1;
        repeat (7) step();

        // Reset one cycle after a handshake.
        raise(0);
        step();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
        repeat (7) step();

        // Single nor request, observed on the LAT=3 instance five cycles later.
        do_reset();
        v_r[0]  = 1'b1;
        a_r[0]  = 8'hAA;
        b_r[0]  = 8'h55;
        op_r[0] = 2'd3;
        repeat (8) step();

        // Random traffic with occasional enable drops and resets.
        for (int c = 0; c < 1500; c++) begin
            enable = ($urandom_range(0, 9) != 0);
            reset  = ($urandom_range(0, 199) != 0);
            for (int i = 0; i < N; i++) begin
                if (!v_r[i] && $urandom_range(0, 2) == 0) raise(i);
            end
            step();
        end
        reset  = 1'b1;
        enable = 1'b1;
        v_r    = '0;
        repeat (7) step();

        // Lone requester 2 granted every cycle, long enough to wrap issued.
        do_reset();
        for (int c = 0; c < 65540; c++) begin
            if (!v_r[2]) raise(2);
            step();
        end
        v_r = '0;
        repeat (7) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
